// File: rtl/mor1kx_wb_retire_marocchino.sv
// Retire/commit controller for the MAROCCHINO write-back stage: owns SR flags,
// ESR/EPCR/EEAR/FPCSR and sequences flush/redirect on exceptions and l.rfe.
`timescale 1ns/1ps
module mor1kx_wb_retire_marocchino #(
    parameter int                              OPTION_OPERAND_WIDTH = 32,
    parameter logic [OPTION_OPERAND_WIDTH-1:0] EXCEPT_VECTOR_BASE   = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pc_wb_i,
    input  logic                            wb_delay_slot_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wb_lsu_adr_i,
    input  logic                            wb_flag_set_i,
    input  logic                            wb_flag_clear_i,
    input  logic                            wb_carry_set_i,
    input  logic                            wb_carry_clear_i,
    input  logic                            wb_overflow_set_i,
    input  logic                            wb_overflow_clear_i,
    input  logic                            wb_atomic_flag_set_i,
    input  logic                            wb_atomic_flag_clear_i,
    input  logic [11:0]                     wb_fpcsr_i,
    input  logic                            wb_fpcsr_set_i,
    input  logic                            wb_except_ibus_err_i,
    input  logic                            wb_except_ipagefault_i,
    input  logic                            wb_except_itlb_miss_i,
    input  logic                            wb_except_ibus_align_i,
    input  logic                            wb_except_illegal_i,
    input  logic                            wb_except_syscall_i,
    input  logic                            wb_except_trap_i,
    input  logic                            wb_except_dbus_i,
    input  logic                            wb_except_dpagefault_i,
    input  logic                            wb_except_dtlb_miss_i,
    input  logic                            wb_except_align_i,
    input  logic                            wb_excepts_en_i,
    input  logic                            wb_op_rfe_i,
    input  logic                            redirect_ack_i,
    output logic                            pipeline_flush_o,
    output logic                            stall_o,
    output logic                            redirect_valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_adr_o,
    output logic [15:0]                     sr_o,
    output logic [15:0]                     esr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] epcr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] eear_o,
    output logic [11:0]                     fpcsr_o
);

    localparam int W = OPTION_OPERAND_WIDTH;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           sm_q, sm_d, f_q, f_d, cy_q, cy_d, ov_q, ov_d, dsx_q, dsx_d;
    logic [15:0]    esr_q, esr_d;
    logic [W-1:0]   epcr_q, epcr_d, eear_q, eear_d, redirect_adr_q, redirect_adr_d;
    logic [11:0]    fpcsr_q, fpcsr_d;

    logic           except_any, syscall_taken, data_taken;
    logic [W-1:0]   vec_off;
    logic           f_upd, cy_upd, ov_upd;
    logic [15:0]    sr_upd;

    // Priority encoder: only the highest-priority strobe selects the vector.
    always_comb begin
        vec_off       = '0;
        syscall_taken = 1'b0;
        data_taken    = 1'b0;
        if (wb_except_itlb_miss_i)        vec_off = W'(12'hA00);
        else if (wb_except_ipagefault_i)  vec_off = W'(12'h400);
        else if (wb_except_ibus_err_i)    vec_off = W'(12'h200);
        else if (wb_except_illegal_i)     vec_off = W'(12'h700);
        else if (wb_except_ibus_align_i)  vec_off = W'(12'h600);
        else if (wb_except_syscall_i) begin
            vec_off       = W'(12'hC00);
            syscall_taken = 1'b1;
        end
        else if (wb_except_trap_i)        vec_off = W'(12'hE00);
        else if (wb_except_dtlb_miss_i) begin
            vec_off    = W'(12'h900);
            data_taken = 1'b1;
        end
        else if (wb_except_dpagefault_i) begin
            vec_off    = W'(12'h300);
            data_taken = 1'b1;
        end
        else if (wb_except_align_i) begin
            vec_off    = W'(12'h600);
            data_taken = 1'b1;
        end
        else if (wb_except_dbus_i) begin
            vec_off    = W'(12'h200);
            data_taken = 1'b1;
        end
    end

    assign except_any = wb_excepts_en_i &
        (wb_except_ibus_err_i | wb_except_ipagefault_i | wb_except_itlb_miss_i |
         wb_except_ibus_align_i | wb_except_illegal_i | wb_except_syscall_i |
         wb_except_trap_i | wb_except_dbus_i | wb_except_dpagefault_i |
         wb_except_dtlb_miss_i | wb_except_align_i);

    // Flag strobes resolve before the ESR snapshot so a same-cycle exception saves them.
    always_comb begin
        f_upd  = (wb_flag_set_i | wb_atomic_flag_set_i) ? 1'b1 :
                 (wb_flag_clear_i | wb_atomic_flag_clear_i) ? 1'b0 : f_q;
        cy_upd = wb_carry_set_i ? 1'b1 : wb_carry_clear_i ? 1'b0 : cy_q;
        ov_upd = wb_overflow_set_i ? 1'b1 : wb_overflow_clear_i ? 1'b0 : ov_q;
        sr_upd = '0;
        sr_upd[0]  = sm_q;
        sr_upd[9]  = f_upd;
        sr_upd[10] = cy_upd;
        sr_upd[11] = ov_upd;
        sr_upd[13] = dsx_q;
    end

    always_comb begin
        state_d        = state_q;
        sm_d           = sm_q;
        f_d            = f_q;
        cy_d           = cy_q;
        ov_d           = ov_q;
        dsx_d          = dsx_q;
        esr_d          = esr_q;
        epcr_d         = epcr_q;
        eear_d         = eear_q;
        fpcsr_d        = fpcsr_q;
        redirect_adr_d = redirect_adr_q;
        unique case (state_q)
            RUN: begin
                f_d  = f_upd;
                cy_d = cy_upd;
                ov_d = ov_upd;
                if (wb_fpcsr_set_i) fpcsr_d = wb_fpcsr_i;
                if (except_any) begin
                    esr_d          = sr_upd;
                    sm_d           = 1'b1;
                    dsx_d          = wb_delay_slot_i;
                    epcr_d         = wb_delay_slot_i ? pc_wb_i - W'(4) :
                                     syscall_taken   ? pc_wb_i + W'(4) : pc_wb_i;
                    eear_d         = data_taken ? wb_lsu_adr_i : pc_wb_i;
                    redirect_adr_d = EXCEPT_VECTOR_BASE + vec_off;
                    state_d        = FLUSH;
                end else if (wb_op_rfe_i) begin
                    sm_d           = esr_q[0];
                    f_d            = esr_q[9];
                    cy_d           = esr_q[10];
                    ov_d           = esr_q[11];
                    dsx_d          = esr_q[13];
                    redirect_adr_d = epcr_q;
                    state_d        = FLUSH;
                end
            end
            FLUSH:    state_d = REDIRECT;
            REDIRECT: if (redirect_ack_i) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            sm_q           <= 1'b1;
            f_q            <= 1'b0;
            cy_q           <= 1'b0;
            ov_q           <= 1'b0;
            dsx_q          <= 1'b0;
            esr_q          <= '0;
            epcr_q         <= '0;
            eear_q         <= '0;
            fpcsr_q        <= '0;
            redirect_adr_q <= '0;
        end else begin
            state_q        <= state_d;
            sm_q           <= sm_d;
            f_q            <= f_d;
            cy_q           <= cy_d;
            ov_q           <= ov_d;
            dsx_q          <= dsx_d;
            esr_q          <= esr_d;
            epcr_q         <= epcr_d;
            eear_q         <= eear_d;
            fpcsr_q        <= fpcsr_d;
            redirect_adr_q <= redirect_adr_d;
        end
    end

    always_comb begin
        sr_o     = '0;
        sr_o[0]  = sm_q;
        sr_o[9]  = f_q;
        sr_o[10] = cy_q;
        sr_o[11] = ov_q;
        sr_o[13] = dsx_q;
    end

    assign pipeline_flush_o = (state_q == FLUSH);
    assign stall_o          = (state_q != RUN);
    assign redirect_valid_o = (state_q == REDIRECT);
    assign redirect_adr_o   = redirect_adr_q;
    assign esr_o            = esr_q;
    assign epcr_o           = epcr_q;
    assign eear_o           = eear_q;
    assign fpcsr_o          = fpcsr_q;

endmodule

// File: tb/tb_mor1kx_wb_retire_marocchino.sv
// Bench for mor1kx_wb_retire_marocchino: exception vector table plus hand-written
// flag, RFE, ignore-while-busy and async-reset sequences; redirect targets via scoreboard.
`timescale 1ns/1ps
module tb_mor1kx_wb_retire_marocchino;

    localparam logic [10:0] E_IBERR = 11'h001, E_IPF = 11'h002, E_ITLB = 11'h004,
                            E_IALGN = 11'h008, E_ILL = 11'h010, E_SYS = 11'h020,
                            E_TRAP = 11'h040, E_DBUS = 11'h080, E_DPF = 11'h100,
                            E_DTLB = 11'h200, E_ALGN = 11'h400;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc_wb_i = '0, wb_lsu_adr_i = '0;
    logic        wb_delay_slot_i = 1'b0;
    logic        wb_flag_set_i = 1'b0, wb_flag_clear_i = 1'b0, wb_carry_set_i = 1'b0;
    logic        wb_carry_clear_i = 1'b0, wb_overflow_set_i = 1'b0, wb_overflow_clear_i = 1'b0;
    logic        wb_atomic_flag_set_i = 1'b0, wb_atomic_flag_clear_i = 1'b0;
    logic [11:0] wb_fpcsr_i = '0;
    logic        wb_fpcsr_set_i = 1'b0;
    logic [10:0] exc = '0;
    logic        wb_excepts_en_i = 1'b0, wb_op_rfe_i = 1'b0, redirect_ack_i = 1'b0;
    logic        pipeline_flush_o, stall_o, redirect_valid_o;
    logic [31:0] redirect_adr_o, epcr_o, eear_o;
    logic [15:0] sr_o, esr_o;
    logic [11:0] fpcsr_o;

    always #5 clk = ~clk;

    mor1kx_wb_retire_marocchino #(
        .OPTION_OPERAND_WIDTH(32),
        .EXCEPT_VECTOR_BASE  (32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_wb_i(pc_wb_i), .wb_delay_slot_i(wb_delay_slot_i),
        .wb_lsu_adr_i(wb_lsu_adr_i),
        .wb_flag_set_i(wb_flag_set_i), .wb_flag_clear_i(wb_flag_clear_i),
        .wb_carry_set_i(wb_carry_set_i), .wb_carry_clear_i(wb_carry_clear_i),
        .wb_overflow_set_i(wb_overflow_set_i), .wb_overflow_clear_i(wb_overflow_clear_i),
        .wb_atomic_flag_set_i(wb_atomic_flag_set_i),
        .wb_atomic_flag_clear_i(wb_atomic_flag_clear_i),
        .wb_fpcsr_i(wb_fpcsr_i), .wb_fpcsr_set_i(wb_fpcsr_set_i),
        .wb_except_ibus_err_i(exc[0]), .wb_except_ipagefault_i(exc[1]),
        .wb_except_itlb_miss_i(exc[2]), .wb_except_ibus_align_i(exc[3]),
        .wb_except_illegal_i(exc[4]), .wb_except_syscall_i(exc[5]),
        .wb_except_trap_i(exc[6]), .wb_except_dbus_i(exc[7]),
        .wb_except_dpagefault_i(exc[8]), .wb_except_dtlb_miss_i(exc[9]),
        .wb_except_align_i(exc[10]),
        .wb_excepts_en_i(wb_excepts_en_i), .wb_op_rfe_i(wb_op_rfe_i),
        .redirect_ack_i(redirect_ack_i),
        .pipeline_flush_o(pipeline_flush_o), .stall_o(stall_o),
        .redirect_valid_o(redirect_valid_o), .redirect_adr_o(redirect_adr_o),
        .sr_o(sr_o), .esr_o(esr_o), .epcr_o(epcr_o), .eear_o(eear_o), .fpcsr_o(fpcsr_o)
    );

    typedef struct {
        logic [10:0] exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] lsu;
        logic        pre_flag;
        logic        rfe;
        int          ack_dly;
        logic [31:0] e_adr, e_epcr, e_eear;
        logic [15:0] e_esr, e_sr;
    } vec_t;

    vec_t        vecs[11];
    int          total = 0, bad = 0;
    logic [31:0] sb_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        exc = '0; wb_excepts_en_i = 1'b0; wb_op_rfe_i = 1'b0; wb_delay_slot_i = 1'b0;
        wb_flag_set_i = 1'b0; wb_flag_clear_i = 1'b0; wb_carry_set_i = 1'b0;
        wb_carry_clear_i = 1'b0; wb_overflow_set_i = 1'b0; wb_overflow_clear_i = 1'b0;
        wb_atomic_flag_set_i = 1'b0; wb_atomic_flag_clear_i = 1'b0; wb_fpcsr_set_i = 1'b0;
        redirect_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Called in the FLUSH cycle; walks REDIRECT, acks after dly cycles, checks return to RUN.
    task automatic redirect_phase(input string tag, input int dly);
        int n;
        logic [31:0] exp_adr;
        tick();
        chk({tag, "_flush_one_cycle"}, pipeline_flush_o, 1'b0);
        n = 0;
        while (!redirect_valid_o && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, redirect_valid_o, 1'b1);
        chk({tag, "_sb_depth"}, sb_q.size(), 1);
        exp_adr = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
        chk({tag, "_adr"}, redirect_adr_o, exp_adr);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk({tag, "_hold_adr"}, redirect_adr_o, exp_adr);
        end
        redirect_ack_i = 1'b1;
        chk({tag, "_valid_at_ack"}, redirect_valid_o, 1'b1);
        chk({tag, "_stall_at_ack"}, stall_o, 1'b1);
        tick();
        redirect_ack_i = 1'b0;
        chk({tag, "_stall_after"}, stall_o, 1'b0);
        chk({tag, "_valid_after"}, redirect_valid_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         exc            pc            ds  lsu           pre rfe dly adr           epcr          eear          esr       sr
        vecs[0]  = '{E_ILL|E_TRAP, 32'h2000,    0, 32'h0,        1,  0,  3,  32'h700, 32'h2000,     32'h2000,     16'h0201, 16'h0201};
        vecs[1]  = '{E_SYS,        32'h1004,    1, 32'h0,        0,  0,  0,  32'hC00, 32'h1000,     32'h1004,     16'h0001, 16'h2001};
        vecs[2]  = '{E_SYS,        32'h1004,    0, 32'h0,        0,  0,  1,  32'hC00, 32'h1008,     32'h1004,     16'h0001, 16'h0001};
        vecs[3]  = '{E_DPF,        32'h4000,    0, 32'hDEAD0000, 0,  0,  0,  32'h300, 32'h4000,     32'hDEAD0000, 16'h0001, 16'h0001};
        vecs[4]  = '{E_ITLB|E_DBUS,32'h5000,    0, 32'h1234,     0,  0,  2,  32'hA00, 32'h5000,     32'h5000,     16'h0001, 16'h0001};
        vecs[5]  = '{E_DBUS,       32'h5000,    0, 32'h1234,     0,  0,  0,  32'h200, 32'h5000,     32'h1234,     16'h0001, 16'h0001};
        vecs[6]  = '{E_IALGN,      32'h0,       1, 32'h0,        0,  0,  0,  32'h600, 32'hFFFFFFFC, 32'h0,        16'h0001, 16'h2001};
        vecs[7]  = '{E_TRAP,       32'h6000,    0, 32'h0,        0,  1,  0,  32'hE00, 32'h6000,     32'h6000,     16'h0001, 16'h0001};
        vecs[8]  = '{E_DTLB|E_DPF, 32'h7000,    0, 32'h8888,     0,  0,  0,  32'h900, 32'h7000,     32'h8888,     16'h0001, 16'h0001};
        vecs[9]  = '{E_ALGN|E_IPF, 32'h9000,    0, 32'h4444,     0,  0,  0,  32'h400, 32'h9000,     32'h9000,     16'h0001, 16'h0001};
        vecs[10] = '{E_ALGN,       32'h9000,    0, 32'h4444,     1,  0,  0,  32'h600, 32'h9000,     32'h4444,     16'h0201, 16'h0201};

        // Reset state and flag strobes.
        do_reset();
        chk("rst_sr", sr_o, 16'h0001);
        chk("rst_esr", esr_o, 16'h0);
        chk("rst_epcr", epcr_o, 32'h0);
        chk("rst_eear", eear_o, 32'h0);
        chk("rst_fpcsr", fpcsr_o, 12'h0);
        chk("rst_ctl", {pipeline_flush_o, stall_o, redirect_valid_o}, 3'b000);
        chk("rst_adr", redirect_adr_o, 32'h0);
        wb_flag_set_i = 1'b1;
        tick();
        clear_in();
        wb_carry_set_i = 1'b1; wb_carry_clear_i = 1'b1;
        tick();
        clear_in();
        chk("flag_carry_sr", sr_o, 16'h0601);
        chk("flag_no_flush", {pipeline_flush_o, stall_o}, 2'b00);
        wb_overflow_set_i = 1'b1; wb_atomic_flag_clear_i = 1'b1;
        tick();
        clear_in();
        chk("ov_set_atomic_clr", sr_o, 16'h0C01);
        wb_overflow_clear_i = 1'b1; wb_atomic_flag_set_i = 1'b1; wb_carry_clear_i = 1'b1;
        wb_fpcsr_i = 12'hABC; wb_fpcsr_set_i = 1'b1;
        tick();
        clear_in();
        chk("ov_clr_atomic_set", sr_o, 16'h0201);
        chk("fpcsr_load", fpcsr_o, 12'hABC);

        // Disabled exceptions do nothing.
        exc = E_DPF; wb_lsu_adr_i = 32'hDEAD0000; pc_wb_i = 32'h4000;
        tick();
        clear_in();
        chk("dis_flush", pipeline_flush_o, 1'b0);
        tick();
        chk("dis_stall", stall_o, 1'b0);
        chk("dis_eear", eear_o, 32'h0);
        chk("dis_sb", sb_q.size(), 0);

        // Table-driven exception vectors.
        foreach (vecs[i]) begin
            do_reset();
            if (vecs[i].pre_flag) begin
                wb_flag_set_i = 1'b1;
                tick();
                clear_in();
            end
            exc = vecs[i].exc; wb_excepts_en_i = 1'b1; wb_op_rfe_i = vecs[i].rfe;
            pc_wb_i = vecs[i].pc; wb_delay_slot_i = vecs[i].ds; wb_lsu_adr_i = vecs[i].lsu;
            sb_q.push_back(vecs[i].e_adr);
            tick();
            clear_in();
            chk($sformatf("v%0d_flush", i), {pipeline_flush_o, stall_o, redirect_valid_o}, 3'b110);
            chk($sformatf("v%0d_epcr", i), epcr_o, vecs[i].e_epcr);
            chk($sformatf("v%0d_eear", i), eear_o, vecs[i].e_eear);
            chk($sformatf("v%0d_esr", i), esr_o, vecs[i].e_esr);
            chk($sformatf("v%0d_sr", i), sr_o, vecs[i].e_sr);
            redirect_phase($sformatf("v%0d", i), vecs[i].ack_dly);
        end

        // Strobes during FLUSH/REDIRECT are ignored.
        do_reset();
        exc = E_ILL; wb_excepts_en_i = 1'b1; pc_wb_i = 32'h100;
        sb_q.push_back(32'h700);
        tick();
        clear_in();
        wb_flag_set_i = 1'b1; wb_fpcsr_i = 12'h555; wb_fpcsr_set_i = 1'b1;
        wb_op_rfe_i = 1'b1; exc = E_TRAP; wb_excepts_en_i = 1'b1; pc_wb_i = 32'h8000;
        redirect_phase("busy", 1);
        clear_in();
        chk("busy_sr", sr_o, 16'h0001);
        chk("busy_fpcsr", fpcsr_o, 12'h0);
        chk("busy_epcr", epcr_o, 32'h100);
        tick();
        chk("busy_no_reentry", stall_o, 1'b0);

        // RFE: clear SM via rfe (ESR=0), build ESR=0x0600 / EPCR=0x3000, then return.
        do_reset();
        wb_op_rfe_i = 1'b1;
        sb_q.push_back(32'h0);
        tick();
        clear_in();
        chk("rfe0_sr", sr_o, 16'h0000);
        redirect_phase("rfe0", 0);
        wb_flag_set_i = 1'b1; wb_carry_set_i = 1'b1;
        tick();
        clear_in();
        exc = E_ILL; wb_excepts_en_i = 1'b1; pc_wb_i = 32'h3000;
        sb_q.push_back(32'h700);
        tick();
        clear_in();
        chk("rfe_setup_esr", esr_o, 16'h0600);
        chk("rfe_setup_epcr", epcr_o, 32'h3000);
        chk("rfe_setup_sr", sr_o, 16'h0601);
        redirect_phase("rfe_setup", 0);
        wb_op_rfe_i = 1'b1;
        sb_q.push_back(32'h3000);
        tick();
        clear_in();
        chk("rfe_sr", sr_o, 16'h0600);
        chk("rfe_flush", pipeline_flush_o, 1'b1);
        redirect_phase("rfe", 2);

        // Async reset while in REDIRECT.
        exc = E_SYS; wb_excepts_en_i = 1'b1; pc_wb_i = 32'h1234;
        tick();
        clear_in();
        tick();
        chk("arst_pre_valid", redirect_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", {pipeline_flush_o, stall_o, redirect_valid_o}, 3'b000);
        chk("arst_adr", redirect_adr_o, 32'h0);
        chk("arst_sr", sr_o, 16'h0001);
        chk("arst_epcr", epcr_o, 32'h0);
        chk("arst_esr", esr_o, 16'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_redirect", {stall_o, redirect_valid_o}, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
